// File: rtl/sprite_write_arbiter.sv
// Round-robin arbiter feeding one pixel per two-cycle SRAM write slot.
// Off-screen and transparent pixels still consume their slot but never strobe a write.
module sprite_write_arbiter #(
    parameter int          N_REQ       = 3,
    parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
    input  logic                  sram_clk,
    input  logic                  reset_n,
    input  logic                  draw_enable,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [10*N_REQ-1:0]   req_x,
    input  logic [10*N_REQ-1:0]   req_y,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [9:0]            program_x,
    output logic [9:0]            program_y,
    output logic [15:0]           program_data,
    output logic                  program_write,
    output logic                  idle
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] win_hi;
    logic [IDX_W-1:0] win_lo;
    logic             found_hi;
    logic             found_lo;
    logic             grant;
    logic [9:0]       win_x;
    logic [9:0]       win_y;
    logic [15:0]      win_data;
    logic             pixel_visible;

    // Round-robin: prefer the lowest valid index above last_grant, else wrap to the lowest valid index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                if (!found_hi && (i > int'(last_grant))) begin
                    found_hi = 1'b1;
                    win_hi   = IDX_W'(i);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = IDX_W'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_x    = '0;
        win_y    = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IDX_W'(i) == winner) begin
                win_x    = req_x[10*i +: 10];
                win_y    = req_y[10*i +: 10];
                win_data = req_data[16*i +: 16];
            end
        end
    end

    // reset_n gates grant so req_ready is low for the whole time reset is held.
    assign grant = reset_n && draw_enable && found_lo && ((state == IDLE) || (state == HOLD1));

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign pixel_visible = (win_x < 10'd640) && (win_y < 10'd480) && (win_data != TRANSPARENT);
    assign idle          = (state == IDLE) && (req_valid == '0);

    always_ff @(posedge sram_clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state         <= IDLE;
            last_grant    <= IDX_W'(N_REQ - 1);
            program_x     <= '0;
            program_y     <= '0;
            program_data  <= '0;
            program_write <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD1: begin
                    if (grant) begin
                        state         <= HOLD0;
                        last_grant    <= winner;
                        program_x     <= win_x;
                        program_y     <= win_y;
                        program_data  <= win_data;
                        program_write <= pixel_visible;
                    end else begin
                        state         <= IDLE;
                        program_write <= 1'b0;
                    end
                end
                HOLD0: begin
                    state <= HOLD1;
                end
                default: begin
                    state         <= IDLE;
                    program_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_write_arbiter.sv
// Scoreboard bench for sprite_write_arbiter: bench-side requesters, round-robin model and slot checker.
module tb_sprite_write_arbiter;

    localparam int N = 3;

    logic            sram_clk    = 1'b0;
    logic            reset_n     = 1'b1;
    logic            draw_enable = 1'b0;
    logic [N-1:0]    req_valid   = '0;
    logic [10*N-1:0] req_x       = '0;
    logic [10*N-1:0] req_y       = '0;
    logic [16*N-1:0] req_data    = '0;
    logic [N-1:0]    req_ready;
    logic [9:0]      program_x;
    logic [9:0]      program_y;
    logic [15:0]     program_data;
    logic            program_write;
    logic            idle;

    sprite_write_arbiter #(.N_REQ(N), .TRANSPARENT(16'hF81F)) dut (
        .sram_clk     (sram_clk),
        .reset_n      (reset_n),
        .draw_enable  (draw_enable),
        .req_valid    (req_valid),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .program_x    (program_x),
        .program_y    (program_y),
        .program_data (program_data),
        .program_write(program_write),
        .idle         (idle)
    );

    always #5 sram_clk = ~sram_clk;

    typedef struct packed {logic [9:0] x; logic [9:0] y; logic [15:0] d;} pix_t;
    typedef struct packed {logic [9:0] x; logic [9:0] y; logic [15:0] d; logic wr;} exp_t;
    typedef enum {M_IDLE, M_H0, M_H1} mstate_t;

    pix_t    pq[N][$];
    exp_t    sb[$];
    int      dut_log[$];
    int      checks = 0;
    int      passes = 0;
    mstate_t m_state = M_IDLE;
    int      m_last  = N - 1;
    logic [N-1:0] obs_ready;
    logic         obs_write;
    logic         obs_idle;

    function automatic int rr_pick(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic visible(pix_t p);
        return (p.x < 10'd640) && (p.y < 10'd480) && (p.d != 16'hF81F);
    endfunction

    task automatic present(int i);
        if (pq[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_x[i*10 +: 10]   = pq[i][0].x;
            req_y[i*10 +: 10]   = pq[i][0].y;
            req_data[i*16 +: 16] = pq[i][0].d;
        end else begin
            req_valid[i] = 1'b0;
        end
    endtask

    task automatic load(int i, logic [9:0] x, logic [9:0] y, logic [15:0] d);
        pix_t p;
        p.x = x;
        p.y = y;
        p.d = d;
        pq[i].push_back(p);
        if (!req_valid[i]) present(i);
    endtask

    // One clock: sample at the falling edge, advance requesters just after the rising edge.
    task automatic step();
        exp_t         e;
        logic [N-1:0] exp_ready;
        logic         exp_idle;
        int           w;
        @(negedge sram_clk);
        obs_ready = req_ready;
        obs_write = program_write;
        obs_idle  = idle;
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_log.push_back(i);

        exp_idle = (m_state == M_IDLE) && (req_valid == '0);
        checks++;
        if (idle !== exp_idle) $display("FAIL idle: got %b expected %b at %0t", idle, exp_idle, $time);
        else passes++;

        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({program_x, program_y, program_data, program_write} !== e)
                $display("FAIL slot: got x=%0d y=%0d d=%h wr=%b expected x=%0d y=%0d d=%h wr=%b at %0t",
                         program_x, program_y, program_data, program_write, e.x, e.y, e.d, e.wr, $time);
            else passes++;
        end else begin
            checks++;
            if (program_write !== 1'b0) $display("FAIL idle_write: got %b expected 0 at %0t", program_write, $time);
            else passes++;
        end

        exp_ready = '0;
        w = -1;
        if ((m_state == M_IDLE || m_state == M_H1) && draw_enable && req_valid != '0) begin
            w = rr_pick(m_last, req_valid);
            exp_ready[w] = 1'b1;
        end
        checks++;
        if (req_ready !== exp_ready) $display("FAIL ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
        else passes++;

        if (w >= 0) begin
            e.x  = pq[w][0].x;
            e.y  = pq[w][0].y;
            e.d  = pq[w][0].d;
            e.wr = visible(pq[w][0]);
            sb.push_back(e);
            sb.push_back(e);
            m_last  = w;
            m_state = M_H0;
        end else begin
            m_state = (m_state == M_H0) ? M_H1 : M_IDLE;
        end

        @(posedge sram_clk);
        #1;
        if (w >= 0) begin
            void'(pq[w].pop_front());
            present(w);
        end
    endtask

    task automatic assert_reset();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({program_x, program_y, program_data, program_write} !== 37'd0)
            $display("FAIL reset_outputs: got x=%0d y=%0d d=%h wr=%b expected all 0",
                     program_x, program_y, program_data, program_write);
        else passes++;
        checks++;
        if (req_ready !== '0) $display("FAIL reset_ready: got %b expected 000", req_ready);
        else passes++;
        sb.delete();
        dut_log.delete();
        m_state = M_IDLE;
        m_last  = N - 1;
    endtask

    task automatic release_reset();
        @(posedge sram_clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        assert_reset();
        checks++;
        if (idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle);
        else passes++;
        release_reset();
        repeat (2) step();
    endtask

    task automatic test_single();
        draw_enable = 1'b1;
        load(0, 10'd5, 10'd7, 16'h1234);
        step();
        checks++;
        if (obs_ready !== 3'b001) $display("FAIL single_grant: got %b expected 001", obs_ready);
        else passes++;
        step();
        checks++;
        if (obs_write !== 1'b1 || program_x !== 10'd5 || program_y !== 10'd7 || program_data !== 16'h1234)
            $display("FAIL single_c1: got wr=%b x=%0d y=%0d d=%h expected wr=1 x=5 y=7 d=1234",
                     obs_write, program_x, program_y, program_data);
        else passes++;
        step();
        checks++;
        if (obs_write !== 1'b1) $display("FAIL single_c2: got %b expected 1", obs_write);
        else passes++;
        step();
        checks++;
        if (obs_idle !== 1'b1) $display("FAIL single_c3_idle: got %b expected 1", obs_idle);
        else passes++;
    endtask

    task automatic test_contention();
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        int writes = 0;
        int bad = 0;
        assert_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                load(i, 10'(100 + 10*i + p), 10'(50 + p), 16'(16'h0100 * (i + 1) + p));
        release_reset();
        repeat (13) begin
            step();
            if (obs_write) writes++;
        end
        for (int k = 0; k < 6; k++) if (k >= dut_log.size() || dut_log[k] != exp_order[k]) bad++;
        checks++;
        if (bad != 0 || dut_log.size() != 6)
            $display("FAIL rr_order: got %0d grants with %0d out of order expected 6 in order 0,1,2,0,1,2",
                     dut_log.size(), bad);
        else passes++;
        checks++;
        if (writes != 12) $display("FAIL rr_throughput: got %0d write cycles expected 12", writes);
        else passes++;
    endtask

    task automatic test_drops();
        int writes = 0;
        assert_reset();
        load(1, 10'd640, 10'd0,   16'h1111);
        load(1, 10'd0,   10'd480, 16'h2222);
        load(1, 10'd1,   10'd1,   16'hF81F);
        load(1, 10'd639, 10'd479, 16'h3333);
        release_reset();
        repeat (7) begin
            step();
            if (obs_write) writes++;
        end
        checks++;
        if (writes != 0 || dut_log.size() != 4)
            $display("FAIL drops: got %0d writes %0d grants expected 0 writes 4 grants", writes, dut_log.size());
        else passes++;
        repeat (2) begin
            step();
            if (obs_write) writes++;
        end
        checks++;
        if (writes != 2) $display("FAIL edge_pixel: got %0d writes expected 2", writes);
        else passes++;
    endtask

    task automatic test_enable();
        int held = 0;
        assert_reset();
        load(0, 10'd10, 10'd10, 16'hAAAA);
        load(2, 10'd20, 10'd20, 16'hBBBB);
        release_reset();
        step();
        draw_enable = 1'b0;
        repeat (5) begin
            step();
            if (obs_ready != '0) held++;
        end
        checks++;
        if (held != 0) $display("FAIL enable_block: got %0d grant cycles expected 0", held);
        else passes++;
        draw_enable = 1'b1;
        step();
        checks++;
        if (obs_ready !== 3'b100) $display("FAIL enable_resume: got %b expected 100", obs_ready);
        else passes++;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        load(2, 10'd30, 10'd40, 16'h0F0F);
        step();
        step();
        checks++;
        if (obs_write !== 1'b1) $display("FAIL mid_hold0: got %b expected 1", obs_write);
        else passes++;
        assert_reset();
        load(1, 10'd1, 10'd2, 16'h1111);
        load(0, 10'd3, 10'd4, 16'h2222);
        #1;
        checks++;
        if (req_ready !== '0) $display("FAIL mid_reset_ready: got %b expected 000", req_ready);
        else passes++;
        release_reset();
        step();
        checks++;
        if (obs_ready !== 3'b001) $display("FAIL mid_first_grant: got %b expected 001", obs_ready);
        else passes++;
        repeat (5) step();
    endtask

    task automatic test_withdraw();
        draw_enable = 1'b0;
        load(1, 10'd9, 10'd9, 16'h9999);
        step();
        pq[1].delete();
        req_valid[1] = 1'b0;
        step();
        checks++;
        if (obs_idle !== 1'b1) $display("FAIL withdraw_idle: got %b expected 1", obs_idle);
        else passes++;
        draw_enable = 1'b1;
        step();
        checks++;
        if (obs_ready !== '0) $display("FAIL withdraw_grant: got %b expected 000", obs_ready);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_drops();
        test_enable();
        test_reset_mid();
        test_withdraw();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
